stream_demux: RTL and testbench

//  Registered 1-to-N stream demultiplexer: inverse of the mux; routes one valid/ready input stream to
//  one of NUM_PORTS output streams selected per beat by in_port. Single-entry output stage gives

---
 rtl/stream_pkg.sv | 30 +++
 rtl/stream_demux.sv | 142 ++++++++++++++
 tb/tb_stream_demux.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
//   Shared definitions for the valid/ready stream blocks.
//   - Default parameter values for the stream demultiplexer.
//   - hold_state_t: occupancy of a single-entry output stage.
//   - sat_inc(): saturating increment for counters up to 32 bits wide.
// ---------------------------------------------------------------------------
package stream_pkg;

    localparam int DATA_SIZE_DEF   = 4;
    localparam int SELECT_SIZE_DEF = 2;
    localparam int NUM_PORTS_DEF   = 4;
    localparam int ERR_SIZE_DEF    = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

    // Returns count + 1, clamped at the all-ones value of a counter that is
    // 'width' bits wide. Callers zero-extend their counter to 32 bits and
    // take back the low 'width' bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] count,
                                            input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (count >= max_val) ? max_val : count + 32'd1;
    endfunction

endpackage

// File: rtl/stream_demux.sv
// ---------------------------------------------------------------------------
// stream_demux
//   Registered 1-to-N valid/ready stream demultiplexer. Each input beat
//   carries its destination in in_port; the beat is captured in a single
//   entry output stage and presented on that port only. A beat that names a
//   port that does not exist is consumed, discarded and counted.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  demux can accept a beat this cycle
//   in_data    in   input beat payload       [DATA_SIZE]
//   in_port    in   destination port         [SELECT_SIZE]
//   out_valid  out  per-port valid, one-hot or zero  [NUM_PORTS]
//   out_ready  in   per-port consumer ready         [NUM_PORTS]
//   out_data   out  per-port payload, all carry the held beat
//   err_count  out  saturating count of beats dropped for a bad port
//
// in_ready depends combinationally on out_ready of the held port so that a
// full stage can drain and refill on the same edge (one beat per clock).
// ---------------------------------------------------------------------------
module stream_demux
    import stream_pkg::*;
#(
    parameter int DATA_SIZE   = DATA_SIZE_DEF,
    parameter int SELECT_SIZE = SELECT_SIZE_DEF,
    parameter int NUM_PORTS   = NUM_PORTS_DEF,
    parameter int ERR_SIZE    = ERR_SIZE_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_SIZE-1:0]   in_data,
    input  logic [SELECT_SIZE-1:0] in_port,
    output logic [NUM_PORTS-1:0]   out_valid,
    input  logic [NUM_PORTS-1:0]   out_ready,
    output logic [DATA_SIZE-1:0]   out_data [NUM_PORTS-1:0],
    output logic [ERR_SIZE-1:0]    err_count
);

    // Elaboration-time parameter sanity.
    if (NUM_PORTS < 1 || NUM_PORTS > (2 ** SELECT_SIZE)) begin : g_bad_ports
        $error("stream_demux: NUM_PORTS must be in 1..2**SELECT_SIZE");
    end
    if (ERR_SIZE < 1 || ERR_SIZE > 32) begin : g_bad_err
        $error("stream_demux: ERR_SIZE must be in 1..32");
    end

    localparam logic [SELECT_SIZE:0] NUM_PORTS_W = (SELECT_SIZE + 1)'(NUM_PORTS);

    hold_state_t            state_q;
    logic [SELECT_SIZE-1:0] held_port_q;
    logic [DATA_SIZE-1:0]   held_data_q;
    logic [ERR_SIZE-1:0]    err_q;
    logic [ERR_SIZE-1:0]    err_d;

    logic        held_valid;
    logic        sel_ready;
    logic        drain;
    logic        port_ok;
    logic        acc;
    logic        acc_valid;
    logic        acc_bad;
    logic [31:0] err_inc_w;

    assign held_valid = (state_q == FULL);

    // Ready of the port currently holding the beat; other ports' ready is
    // deliberately ignored.
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (held_port_q == SELECT_SIZE'(i)) begin
                sel_ready = out_ready[i];
            end
        end
    end

    assign drain     = held_valid & sel_ready;
    assign in_ready  = ~held_valid | drain;
    assign port_ok   = ({1'b0, in_port} < NUM_PORTS_W);
    assign acc       = in_valid & in_ready;
    assign acc_valid = acc & port_ok;
    assign acc_bad   = acc & ~port_ok;

    assign err_inc_w = sat_inc(32'(err_q), ERR_SIZE);
    assign err_d     = acc_bad ? err_inc_w[ERR_SIZE-1:0] : err_q;

    if (ERR_SIZE < 32) begin : g_sat_sink
        // Upper bits of the shared 32-bit helper result are always zero here.
        logic [31-ERR_SIZE:0] sat_unused_w;
        assign sat_unused_w = err_inc_w[31:ERR_SIZE];
    end

    // Output stage. A bad-port beat never loads the held registers, so a
    // drain on the same edge simply empties the stage.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            held_port_q <= '0;
            held_data_q <= '0;
            err_q       <= '0;
        end else begin
            err_q <= err_d;
            case (state_q)
                EMPTY: begin
                    if (acc_valid) begin
                        state_q     <= FULL;
                        held_port_q <= in_port;
                        held_data_q <= in_data;
                    end
                end
                FULL: begin
                    if (acc_valid) begin
                        // acc_valid implies drain here: back-to-back refill.
                        held_port_q <= in_port;
                        held_data_q <= in_data;
                    end else if (drain) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            out_valid[i] = held_valid & (held_port_q == SELECT_SIZE'(i));
            out_data[i]  = held_data_q;
        end
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_stream_demux.sv
// ---------------------------------------------------------------------------
// tb_stream_demux
//   Directed bench for stream_demux with DATA_SIZE=4, SELECT_SIZE=2,
//   NUM_PORTS=3 (port 3 is a bad port), ERR_SIZE=8. Inputs are driven 1 time
//   unit after the rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_stream_demux;

    localparam int DW = 4;
    localparam int SW = 2;
    localparam int NP = 3;
    localparam int EW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_port;
    logic [NP-1:0] out_valid;
    logic [NP-1:0] out_ready;
    logic [DW-1:0] out_data [NP-1:0];
    logic [EW-1:0] err_count;

    int checks = 0;
    int passes = 0;

    stream_demux #(
        .DATA_SIZE  (DW),
        .SELECT_SIZE(SW),
        .NUM_PORTS  (NP),
        .ERR_SIZE   (EW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_port  (in_port),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound: the directed sequence needs a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] p,
                         input logic [DW-1:0] d);
        in_valid = v;
        in_port  = p;
        in_data  = d;
    endtask

    initial begin
        rst_n     = 1'b1;
        out_ready = '0;
        drive(1'b0, '0, '0);

        // 1 Reset asserted between edges takes effect without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_err", 32'(err_count), 32'h0);
        check("rst_data0", 32'(out_data[0]), 32'h0);
        check("rst_data2", 32'(out_data[2]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 2 Routing, one beat per clock.
        out_ready = 3'b111;
        drive(1'b1, 2'd0, 4'hE);
        check("route_rdy0", 32'(in_ready), 32'h1);
        step();
        check("route_v0", 32'(out_valid), 32'h1);
        check("route_d0", 32'(out_data[0]), 32'hE);
        drive(1'b1, 2'd1, 4'hC);
        check("route_rdy1", 32'(in_ready), 32'h1);
        step();
        check("route_v1", 32'(out_valid), 32'h2);
        check("route_d1", 32'(out_data[1]), 32'hC);
        drive(1'b1, 2'd2, 4'hA);
        check("route_rdy2", 32'(in_ready), 32'h1);
        step();
        check("route_v2", 32'(out_valid), 32'h4);
        check("route_d2", 32'(out_data[2]), 32'hA);
        drive(1'b0, '0, '0);
        step();
        check("route_idle", 32'(out_valid), 32'h0);

        // 3 Backpressure on port 1; ready of port 0 must not drain it.
        out_ready = 3'b001;
        drive(1'b1, 2'd1, 4'h5);
        step();
        drive(1'b1, 2'd2, 4'h9);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'h2);
            check("bp_data", 32'(out_data[1]), 32'h5);
            check("bp_in_ready", 32'(in_ready), 32'h0);
            step();
        end
        out_ready = 3'b010;
        #1;
        check("bp_release_rdy", 32'(in_ready), 32'h1);
        step();
        check("bp_next_valid", 32'(out_valid), 32'h4);
        check("bp_next_data", 32'(out_data[2]), 32'h9);
        out_ready = 3'b111;
        drive(1'b0, '0, '0);
        step();
        check("bp_idle", 32'(out_valid), 32'h0);

        // 4 Bad port: beats dropped and counted, counter saturates at 255.
        drive(1'b1, 2'd3, 4'hF);
        check("bad_rdy", 32'(in_ready), 32'h1);
        step();
        check("bad_v1", 32'(out_valid), 32'h0);
        step();
        check("bad_v2", 32'(out_valid), 32'h0);
        check("bad_err2", 32'(err_count), 32'h2);
        for (int i = 2; i < 254; i++) step();
        check("bad_err254", 32'(err_count), 32'hFE);
        step();
        check("bad_err255", 32'(err_count), 32'hFF);
        for (int i = 255; i < 300; i++) step();
        check("bad_err_sat", 32'(err_count), 32'hFF);
        check("bad_no_valid", 32'(out_valid), 32'h0);
        drive(1'b0, '0, '0);
        step();

        // 6 Reset while a beat is stalled in the stage.
        out_ready = 3'b000;
        drive(1'b1, 2'd0, 4'h3);
        step();
        drive(1'b0, '0, '0);
        check("rst_full_valid", 32'(out_valid), 32'h1);
        check("rst_full_rdy", 32'(in_ready), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'h0);
        check("rst_mid_rdy", 32'(in_ready), 32'h1);
        check("rst_mid_err", 32'(err_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_after_idle", 32'(out_valid), 32'h0);
        out_ready = 3'b111;
        drive(1'b1, 2'd1, 4'hB);
        check("rst_after_pre", 32'(out_valid), 32'h0);
        step();
        check("rst_after_valid", 32'(out_valid), 32'h2);
        check("rst_after_data", 32'(out_data[1]), 32'hB);
        drive(1'b0, '0, '0);
        step();

        // 5 Held beat drains on the same edge a bad-port beat is accepted.
        out_ready = 3'b000;
        drive(1'b1, 2'd2, 4'h7);
        step();
        drive(1'b1, 2'd3, 4'hF);
        check("sim_held", 32'(out_valid), 32'h4);
        check("sim_stall_rdy", 32'(in_ready), 32'h0);
        step();
        check("sim_stall_err", 32'(err_count), 32'h0);
        out_ready = 3'b100;
        #1;
        check("sim_rdy", 32'(in_ready), 32'h1);
        step();
        check("sim_valid", 32'(out_valid), 32'h0);
        check("sim_err", 32'(err_count), 32'h1);
        drive(1'b0, '0, '0);
        step();
        check("sim_final_rdy", 32'(in_ready), 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
